// File: rtl/shared_mem_arbiter_if.sv
// Bundle between the execution cores and the shared device-memory port.
// The arbiter uses the slave view; the cores/memory side uses the master view.
interface shared_mem_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    core_request;
    logic [NUM_CORES-1:0]    core_wren;
    logic [NUM_CORES-1:0]    core_rden;
    logic [16*NUM_CORES-1:0] core_addr;
    logic [16*NUM_CORES-1:0] core_write_val;
    logic [NUM_CORES-1:0]    core_enable;
    logic [15:0]             mem_addr;
    logic                    mem_wren;
    logic                    mem_rden;
    logic [15:0]             mem_write_val;
    logic [15:0]             mem_read_val;
    logic [15:0]             core_read_val;
    logic [3:0]              read_owner;
    logic                    read_owner_valid;
    logic [31:0]             contention_count;

    modport slave (
        input  core_request, core_wren, core_rden, core_addr, core_write_val, mem_read_val,
        output core_enable, mem_addr, mem_wren, mem_rden, mem_write_val, core_read_val,
        output read_owner, read_owner_valid, contention_count
    );

    modport master (
        output core_request, core_wren, core_rden, core_addr, core_write_val, mem_read_val,
        input  core_enable, mem_addr, mem_wren, mem_rden, mem_write_val, core_read_val,
        input  read_owner, read_owner_valid, contention_count
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one device-memory port among NUM_CORES cores,
// with a bounded hold so a busy core cannot starve the others.
module shared_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    shared_mem_arbiter_if.slave   bus
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [3:0]        last_owner_q, last_owner_d;
    logic              owner_valid_q, owner_valid_d;
    logic [HOLD_W-1:0] hold_count_q, hold_count_d;
    logic [3:0]        read_owner_q, read_owner_d;
    logic              read_owner_valid_q, read_owner_valid_d;
    logic [31:0]       contention_count_q, contention_count_d;

    logic              grant_vld;
    logic [3:0]        grant_idx;
    logic              hold_ok;
    logic [4:0]        cand_sum;
    logic [16*NUM_CORES-1:0] addr_sh;
    logic [16*NUM_CORES-1:0] wval_sh;

    function automatic logic bit_at(input logic [NUM_CORES-1:0] v, input logic [3:0] i);
        return |(v & (NUM_CORES'(1) << i));
    endfunction

    // Grant: keep the current owner while under its hold budget, otherwise
    // search from last_owner+1 around to last_owner itself.
    always_comb begin
        hold_ok   = owner_valid_q && bit_at(bus.core_request, last_owner_q)
                    && (int'(hold_count_q) < MAX_HOLD - 1);
        grant_vld = 1'b0;
        grant_idx = last_owner_q;
        cand_sum  = '0;
        if (hold_ok) begin
            grant_vld = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                cand_sum = {1'b0, last_owner_q} + 5'(k);
                if (cand_sum >= 5'(NUM_CORES)) begin
                    cand_sum = cand_sum - 5'(NUM_CORES);
                end
                if (!grant_vld && bit_at(bus.core_request, cand_sum[3:0])) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_sum[3:0];
                end
            end
        end
        // Nothing reaches the memory port while reset is held.
        grant_vld = grant_vld && reset_n;
    end

    always_comb begin
        addr_sh = bus.core_addr >> {grant_idx, 4'b0000};
        wval_sh = bus.core_write_val >> {grant_idx, 4'b0000};

        bus.core_enable   = grant_vld ? (NUM_CORES'(1) << grant_idx) : '0;
        bus.mem_addr      = grant_vld ? addr_sh[15:0] : 16'h0000;
        bus.mem_write_val = grant_vld ? wval_sh[15:0] : 16'h0000;
        bus.mem_wren      = grant_vld && bit_at(bus.core_wren, grant_idx);
        bus.mem_rden      = grant_vld && bit_at(bus.core_rden, grant_idx);
        bus.core_read_val = bus.mem_read_val;
        bus.read_owner       = read_owner_q;
        bus.read_owner_valid = read_owner_valid_q;
        bus.contention_count = contention_count_q;
    end

    always_comb begin
        last_owner_d       = last_owner_q;
        owner_valid_d      = 1'b0;
        hold_count_d       = '0;
        read_owner_d       = read_owner_q;
        read_owner_valid_d = 1'b0;
        contention_count_d = contention_count_q;

        if (grant_vld) begin
            last_owner_d       = grant_idx;
            owner_valid_d      = 1'b1;
            read_owner_d       = grant_idx;
            read_owner_valid_d = bit_at(bus.core_rden, grant_idx);
            if (grant_idx == last_owner_q && owner_valid_q) begin
                hold_count_d = (int'(hold_count_q) < MAX_HOLD - 1)
                               ? hold_count_q + HOLD_W'(1) : hold_count_q;
            end
        end

        if ($countones(bus.core_request) >= 2 && contention_count_q != 32'hFFFF_FFFF) begin
            contention_count_d = contention_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner_q       <= 4'(NUM_CORES - 1);
            owner_valid_q      <= 1'b0;
            hold_count_q       <= '0;
            read_owner_q       <= 4'd0;
            read_owner_valid_q <= 1'b0;
            contention_count_q <= 32'd0;
        end else begin
            last_owner_q       <= last_owner_d;
            owner_valid_q      <= owner_valid_d;
            hold_count_q       <= hold_count_d;
            read_owner_q       <= read_owner_d;
            read_owner_valid_q <= read_owner_valid_d;
            contention_count_q <= contention_count_d;
        end
    end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a MAX_HOLD=2 instance (A) and a
// MAX_HOLD=1 instance (B) driven by the same core-side stimulus.
module tb_shared_mem_arbiter;
    logic        clk;
    logic        reset_n;
    logic [3:0]  req, wr, rd;
    logic [63:0] addr, wval;
    logic [15:0] mrv;

    int checks;
    int errors;

    shared_mem_arbiter_if #(.NUM_CORES(4)) ifa ();
    shared_mem_arbiter_if #(.NUM_CORES(4)) ifb ();

    assign ifa.core_request   = req;
    assign ifa.core_wren      = wr;
    assign ifa.core_rden      = rd;
    assign ifa.core_addr      = addr;
    assign ifa.core_write_val = wval;
    assign ifa.mem_read_val   = mrv;
    assign ifb.core_request   = req;
    assign ifb.core_wren      = wr;
    assign ifb.core_rden      = rd;
    assign ifb.core_addr      = addr;
    assign ifb.core_write_val = wval;
    assign ifb.mem_read_val   = mrv;

    shared_mem_arbiter #(.NUM_CORES(4), .MAX_HOLD(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    shared_mem_arbiter #(.NUM_CORES(4), .MAX_HOLD(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req, wr, rd;
        logic [15:0] mrv;
        logic [3:0]  en;
        logic        mwr, mrd;
        logic [15:0] maddr, mwval;
        logic        rov;
        logic [3:0]  ro;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 4'b0; wr = 4'b0; rd = 4'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // core3..core0 slices
        addr = {16'h8000, 16'h4010, 16'h0123, 16'h0A00};
        wval = {16'hBEEF, 16'h2222, 16'h1111, 16'h0F0F};
        mrv  = 16'h0000;

        //          req      wr       rd       mrv       en       mwr   mrd   maddr     mwval     rov   ro
        tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0};
        tbl[1] = '{4'b0100, 4'b0000, 4'b0100, 16'h0000, 4'b0100, 1'b0, 1'b1, 16'h4010, 16'h2222, 1'b0, 4'd0};
        tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 16'hA5A5, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 4'd2};
        tbl[3] = '{4'b1000, 4'b1000, 4'b0000, 16'h0000, 4'b1000, 1'b1, 1'b0, 16'h8000, 16'hBEEF, 1'b0, 4'd0};
        tbl[4] = '{4'b0010, 4'b0000, 4'b0010, 16'h0000, 4'b0010, 1'b0, 1'b1, 16'h0123, 16'h1111, 1'b0, 4'd0};
        tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 16'h1234, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 4'd1};
        tbl[6] = '{4'b0101, 4'b0000, 4'b0000, 16'h0000, 4'b0100, 1'b0, 1'b0, 16'h4010, 16'h2222, 1'b0, 4'd0};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0};
        tbl[8] = '{4'b0001, 4'b0001, 4'b0001, 16'h0000, 4'b0001, 1'b1, 1'b1, 16'h0A00, 16'h0F0F, 1'b0, 4'd0};
        tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 16'h5A5A, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0};

        // Reset state with requests present: outputs are forced low.
        reset_n = 1'b0;
        req = 4'b1111; wr = 4'b1111; rd = 4'b1111;
        #2;
        chk("rst_en_a", 64'(ifa.core_enable), 64'h0);
        chk("rst_en_b", 64'(ifb.core_enable), 64'h0);
        chk("rst_wren", 64'(ifa.mem_wren), 64'h0);
        chk("rst_rden", 64'(ifa.mem_rden), 64'h0);
        chk("rst_rov", 64'(ifa.read_owner_valid), 64'h0);
        chk("rst_cnt", 64'(ifa.contention_count), 64'h0);
        step();
        reset_n = 1'b1;
        req = 4'b0; wr = 4'b0; rd = 4'b0;

        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; wr = tbl[i].wr; rd = tbl[i].rd; mrv = tbl[i].mrv;
            #1;
            chk($sformatf("v%0d_en_a", i), 64'(ifa.core_enable), 64'(tbl[i].en));
            chk($sformatf("v%0d_en_b", i), 64'(ifb.core_enable), 64'(tbl[i].en));
            chk($sformatf("v%0d_wren", i), 64'(ifa.mem_wren), 64'(tbl[i].mwr));
            chk($sformatf("v%0d_rden", i), 64'(ifa.mem_rden), 64'(tbl[i].mrd));
            chk($sformatf("v%0d_addr", i), 64'(ifa.mem_addr), 64'(tbl[i].maddr));
            chk($sformatf("v%0d_wval", i), 64'(ifa.mem_write_val), 64'(tbl[i].mwval));
            chk($sformatf("v%0d_rov", i), 64'(ifa.read_owner_valid), 64'(tbl[i].rov));
            chk($sformatf("v%0d_rdval", i), 64'(ifa.core_read_val), 64'(tbl[i].mrv));
            if (tbl[i].rov) begin
                chk($sformatf("v%0d_ro", i), 64'(ifa.read_owner), 64'(tbl[i].ro));
            end
            step();
        end
        chk("table_cnt_a", 64'(ifa.contention_count), 64'd1);

        // Four cores requesting continuously.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [3:0] exp_a, exp_b;
            exp_a = 4'b0001 << ((i / 2) % 4);
            exp_b = 4'b0001 << (i % 4);
            req = 4'b1111;
            #1;
            chk($sformatf("rr4_%0d_a", i), 64'(ifa.core_enable), 64'(exp_a));
            chk($sformatf("rr4_%0d_b", i), 64'(ifb.core_enable), 64'(exp_b));
            step();
        end
        req = 4'b0000;
        #1;
        chk("rr4_cnt_a", 64'(ifa.contention_count), 64'd8);
        chk("rr4_cnt_b", 64'(ifb.contention_count), 64'd8);

        // Two cores: hold limit of 2 on A, strict alternation on B.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [3:0] exp_a, exp_b;
            exp_a = 4'b0001 << ((i / 2) % 2);
            exp_b = 4'b0001 << (i % 2);
            req = 4'b0011;
            #1;
            chk($sformatf("hold_%0d_a", i), 64'(ifa.core_enable), 64'(exp_a));
            chk($sformatf("hold_%0d_b", i), 64'(ifb.core_enable), 64'(exp_b));
            step();
        end
        req = 4'b0000;
        #1;
        chk("hold_cnt_a", 64'(ifa.contention_count), 64'd6);
        step();

        // Reset asserted during a granted read.
        req = 4'b0100; rd = 4'b0100;
        #1;
        chk("rr_read_en", 64'(ifa.core_enable), 64'b0100);
        step();
        #1;
        chk("rr_read_en2", 64'(ifa.core_enable), 64'b0100);
        chk("rr_read_rov", 64'(ifa.read_owner_valid), 64'h1);
        chk("rr_read_ro", 64'(ifa.read_owner), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'(ifa.core_enable), 64'h0);
        chk("mid_rst_rden", 64'(ifa.mem_rden), 64'h0);
        chk("mid_rst_rov", 64'(ifa.read_owner_valid), 64'h0);
        step();
        reset_n = 1'b1;
        req = 4'b1111; rd = 4'b0000;
        #1;
        chk("post_rst_en", 64'(ifa.core_enable), 64'b0001);
        chk("post_rst_rov", 64'(ifa.read_owner_valid), 64'h0);
        chk("post_rst_cnt", 64'(ifa.contention_count), 64'h0);
        step();
        req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
